dkong_hs_ram_arb: RTL and testbench
===================================

Name: dkong_hs_ram_arb

Overview:
- Arbitrates the single CPU-side port of the sprite work RAM (the 1 KB block at 0x6800–0x6BFF, whose other port feeds the sprite DMA) between the Z80 and the hiscore load/save interface.
- Replaces the static hs_access multiplexer.
- Hiscore accesses become request/acknowledge transactions.
- The CPU is stalled through a WAIT output only when a hiscore access actually owns the port.
- The block sits between the address decoder / hiscore interface and the RAM's A port.

Parameters:
AW, 10, RAM address width
DW, 8, RAM data width
STARVE, 64, clock cycles a pending hiscore request may wait behind continuous CPU selection before the arbiter forces a CPU wait state

Ports:
I_CLK  in  1  system clock (24.576 MHz)
I_RESET_n  in  1  asynchronous active-low reset
I_CPU_A  in  AW  CPU address
I_CPU_D  in  DW  CPU write data
I_CPU_CE  in  1  RAM chip select from the address decoder, active high, held for the whole bus cycle
I_CPU_WE  in  1  CPU write strobe, active high
O_CPU_DO  out  DW  read data to the CPU OR-bus; 0 unless the CPU is granted and I_CPU_CE=1
O_WAIT_n  out  1  CPU wait request, active low, ANDed into the Z80 WAIT_n
I_HS_REQ  in  1  hiscore request (four-phase level)
I_HS_WE  in  1  hiscore write, sampled with the request
I_HS_A  in  AW  hiscore address
I_HS_D  in  DW  hiscore write data
O_HS_ACK  out  1  hiscore acknowledge
O_HS_DO  out  DW  hiscore read data, valid while O_HS_ACK=1
O_RAM_A  out  AW  RAM address
O_RAM_D  out  DW  RAM write data
O_RAM_CE  out  1  RAM enable
O_RAM_WE  out  1  RAM write enable
I_RAM_Q  in  DW  RAM read data (synchronous, 1 cycle latency)

Behaviour:
- Interface decision: one clock, I_CLK; reset I_RESET_n is asynchronous, active-low.
- State machine states: IDLE, HS_ACC, HS_LAT, HS_ACK, RESTORE.
- Reset values: state=IDLE, O_WAIT_n=1, O_HS_ACK=0, O_HS_DO=0, starve counter=0.
- IDLE:
  - RAM port is driven combinationally from the CPU inputs (O_RAM_CE=I_CPU_CE, O_RAM_WE=I_CPU_CE&I_CPU_WE).
  - O_CPU_DO=I_RAM_Q when I_CPU_CE=1.
  - Go to HS_ACC when I_HS_REQ=1 and either I_CPU_CE=0 or starve counter=STARVE.
  - The hiscore request wins only if the CPU is not selecting RAM in that same cycle, or if starvation has been reached.
- HS_ACC (1 cycle):
  - Drives I_HS_A/I_HS_D/I_HS_WE, O_RAM_CE=1.
  - O_WAIT_n=0 if I_CPU_CE=1.
  - Next state: HS_LAT.
- HS_LAT (1 cycle):
  - RAM port idle (CE=0).
  - Captures I_RAM_Q into O_HS_DO; on writes O_HS_DO holds I_HS_D.
  - Next state: HS_ACK.
- HS_ACK:
  - O_HS_ACK=1.
  - Stays in HS_ACK until I_HS_REQ=0.
  - On exit O_HS_ACK drops on the next cycle.
  - Goes to RESTORE if I_CPU_CE=1, else IDLE.
- RESTORE (1 cycle):
  - RAM port driven from the CPU so the read output again reflects I_CPU_A.
  - O_WAIT_n=0.
  - Next state: IDLE, where O_WAIT_n returns to 1.
- O_WAIT_n is 0 in HS_ACC/HS_LAT/HS_ACK/RESTORE whenever I_CPU_CE=1, and 1 in IDLE.
- A CPU write held during a stall is performed only after RESTORE, i.e. once, never during hiscore states.
- Starve counter:
  - Increments (saturating at STARVE) each cycle that I_HS_REQ=1, I_CPU_CE=1 and state=IDLE.
  - Clears when HS_ACC is entered or I_HS_REQ=0.
- Simultaneous I_CPU_CE rise and I_HS_REQ in IDLE: CPU wins unless the counter is saturated.
- I_HS_A/I_HS_D/I_HS_WE must be stable from I_HS_REQ rise until O_HS_ACK; the block does not latch them.
- I_HS_REQ dropping before ACK is a protocol error: the transaction still completes and the ACK pulses for 1 cycle.
- Reset asserted mid-transaction: immediate return to IDLE, ACK=0, WAIT_n=1, no RAM write after reset.

Test Plan:
- Reset, CPU reads 0x6900 with no hiscore traffic -> O_WAIT_n stays 1, O_CPU_DO equals the preloaded RAM byte one cycle after CE, O_HS_ACK=0.
- CPU idle, hiscore write 0x5A to address 0x0A0 -> HS_ACC after 1 cycle, O_RAM_WE=1 for exactly 1 cycle, ACK high 2 cycles after entering HS_ACC, held until REQ falls; CPU readback of 0x68A0 returns 0x5A.
- Hiscore read in progress, CPU selects RAM during HS_LAT -> O_WAIT_n=0 through HS_ACK and RESTORE, CPU read returns the correct byte for its own address, hiscore O_HS_DO correct.
- CPU holds I_CPU_CE continuously, I_HS_REQ asserted -> forced HS_ACC exactly after STARVE (64) cycles; no CPU write is lost or duplicated (RAM write count checked).
- Simultaneous I_CPU_CE rise and I_HS_REQ with counter 0 -> CPU served, hiscore deferred, no wait.
- Reset pulsed during HS_ACK with a CPU stall active -> O_WAIT_n=1 and O_HS_ACK=0 asynchronously, state IDLE, next hiscore transaction completes normally.

Source files
------------

// File: rtl/dkong_hs_ram_arb.sv
`timescale 1ns/1ps
// dkong_hs_ram_arb
// Arbitrates the CPU-side port of the 1 KB sprite work RAM between the Z80
// and the hiscore load/save interface. The CPU owns the port by default and
// is only stalled (O_WAIT_n low) while a hiscore access actually holds it.
//
// Hiscore handshake (four-phase level protocol):
//   requester raises I_HS_REQ with I_HS_A/I_HS_D/I_HS_WE stable -> arbiter
//   performs one RAM access and raises O_HS_ACK with O_HS_DO valid ->
//   requester drops I_HS_REQ -> arbiter drops O_HS_ACK on the next cycle.
//   Address/data/we are not latched; they must stay stable until O_HS_ACK.
//   A request that drops before ACK still completes and ACK pulses once.
module dkong_hs_ram_arb #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int STARVE = 64
) (
  input  logic          I_CLK,
  input  logic          I_RESET_n,
  input  logic [AW-1:0] I_CPU_A,
  input  logic [DW-1:0] I_CPU_D,
  input  logic          I_CPU_CE,
  input  logic          I_CPU_WE,
  output logic [DW-1:0] O_CPU_DO,
  output logic          O_WAIT_n,
  input  logic          I_HS_REQ,
  input  logic          I_HS_WE,
  input  logic [AW-1:0] I_HS_A,
  input  logic [DW-1:0] I_HS_D,
  output logic          O_HS_ACK,
  output logic [DW-1:0] O_HS_DO,
  output logic [AW-1:0] O_RAM_A,
  output logic [DW-1:0] O_RAM_D,
  output logic          O_RAM_CE,
  output logic          O_RAM_WE,
  input  logic [DW-1:0] I_RAM_Q,
  output logic [2:0]    O_DBG_STATE
);

  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HS_ACC  = 3'd1,
    S_HS_LAT  = 3'd2,
    S_HS_ACK  = 3'd3,
    S_RESTORE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_starve;
  logic [DW-1:0]   r_hs_do;
  logic            w_starved;
  logic            w_enter_acc;

  assign w_starved   = (r_starve == STARVE_MAX);
  assign w_enter_acc = (r_state == S_IDLE) && (w_next == S_HS_ACC);

  assign O_HS_ACK    = (r_state == S_HS_ACK);
  assign O_HS_DO     = r_hs_do;
  assign O_DBG_STATE = r_state;

  // State register; reset drops any transaction in flight immediately.
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and RAM-port steering; CPU passes through only in IDLE/RESTORE.
  always_comb begin
    w_next   = r_state;
    O_RAM_A  = I_CPU_A;
    O_RAM_D  = I_CPU_D;
    O_RAM_CE = 1'b0;
    O_RAM_WE = 1'b0;
    O_CPU_DO = '0;
    O_WAIT_n = 1'b1;
    case (r_state)
      S_IDLE: begin
        O_RAM_CE = I_CPU_CE;
        O_RAM_WE = I_CPU_CE & I_CPU_WE;
        if (I_CPU_CE) begin
          O_CPU_DO = I_RAM_Q;
        end
        // CPU keeps the port while selecting RAM unless the request starved.
        if (I_HS_REQ && (!I_CPU_CE || w_starved)) begin
          w_next = S_HS_ACC;
        end
      end
      S_HS_ACC: begin
        O_RAM_A  = I_HS_A;
        O_RAM_D  = I_HS_D;
        O_RAM_CE = 1'b1;
        O_RAM_WE = I_HS_WE;
        O_WAIT_n = ~I_CPU_CE;
        w_next   = S_HS_LAT;
      end
      S_HS_LAT: begin
        O_WAIT_n = ~I_CPU_CE;
        w_next   = S_HS_ACK;
      end
      S_HS_ACK: begin
        O_WAIT_n = ~I_CPU_CE;
        if (!I_HS_REQ) begin
          w_next = I_CPU_CE ? S_RESTORE : S_IDLE;
        end
      end
      S_RESTORE: begin
        // Re-read the CPU address so the read data is valid back in IDLE;
        // a held CPU write is deferred to IDLE so it happens exactly there.
        O_RAM_CE = I_CPU_CE;
        O_WAIT_n = ~I_CPU_CE;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Starvation counter: counts IDLE cycles a request loses to the CPU.
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      r_starve <= '0;
    end else if (!I_HS_REQ || w_enter_acc) begin
      r_starve <= '0;
    end else if ((r_state == S_IDLE) && I_CPU_CE && !w_starved) begin
      r_starve <= r_starve + CW'(1);
    end
  end

  // Hiscore read data capture; a write reports back the data it wrote.
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      r_hs_do <= '0;
    end else if (r_state == S_HS_LAT) begin
      r_hs_do <= I_HS_WE ? I_HS_D : I_RAM_Q;
    end
  end

endmodule

// File: tb/tb_dkong_hs_ram_arb.sv
`timescale 1ns/1ps
// Bench for dkong_hs_ram_arb with a synchronous 1 KB RAM model.
module tb_dkong_hs_ram_arb;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int STARVE = 64;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HS_ACC  = 3'd1;
  localparam logic [2:0] ST_HS_LAT  = 3'd2;
  localparam logic [2:0] ST_HS_ACK  = 3'd3;
  localparam logic [2:0] ST_RESTORE = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #20 clk = ~clk;
  logic rst_n;

  logic [AW-1:0] cpu_a, hs_a, ram_a;
  logic [DW-1:0] cpu_d, hs_d, cpu_do, hs_do, ram_d, ram_q;
  logic          cpu_ce, cpu_we, hs_req, hs_we;
  logic          wait_n, hs_ack, ram_ce, ram_we;
  logic [2:0]    dbg_state;

  dkong_hs_ram_arb #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .I_CLK(clk), .I_RESET_n(rst_n),
    .I_CPU_A(cpu_a), .I_CPU_D(cpu_d), .I_CPU_CE(cpu_ce), .I_CPU_WE(cpu_we),
    .O_CPU_DO(cpu_do), .O_WAIT_n(wait_n),
    .I_HS_REQ(hs_req), .I_HS_WE(hs_we), .I_HS_A(hs_a), .I_HS_D(hs_d),
    .O_HS_ACK(hs_ack), .O_HS_DO(hs_do),
    .O_RAM_A(ram_a), .O_RAM_D(ram_d), .O_RAM_CE(ram_ce), .O_RAM_WE(ram_we),
    .I_RAM_Q(ram_q), .O_DBG_STATE(dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] shadow [0:1023];
  int wr_cnt = 0;
  int busy_wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        mem[ram_a] <= ram_d;
        wr_cnt <= wr_cnt + 1;
        if (dbg_state != ST_IDLE) busy_wr_cnt <= busy_wr_cnt + 1;
      end
      ram_q <= mem[ram_a];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;

  function automatic logic [DW-1:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cpu_read(input logic [AW-1:0] a, output int lat);
    cpu_a = a; cpu_we = 1'b0; cpu_ce = 1'b1;
    exp_q.push_back(shadow[a]);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!wait_n && lat < 100);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (!wait_n) begin
      n_err++; $display("FAIL cpu_read_timeout: wait_n=%b required 1", wait_n);
    end else if (cpu_do !== exp_v) begin
      n_err++; $display("FAIL cpu_read[%h]: got %h required %h", a, cpu_do, exp_v);
    end
    cpu_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic hs_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t;
    hs_we = we; hs_a = a; hs_d = d; hs_req = 1'b1;
    if (we) begin shadow[a] = d; exp_q.push_back(d); end
    else exp_q.push_back(shadow[a]);
    t = 0;
    do begin @(negedge clk); t++; end while (!hs_ack && t < 200);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (!hs_ack) begin
      n_err++; $display("FAIL hs_ack_timeout: ack=%b required 1", hs_ack);
    end else if (hs_do !== exp_v) begin
      n_err++; $display("FAIL hs_do[%h]: got %h required %h", a, hs_do, exp_v);
    end
    hs_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (hs_ack !== 1'b0) begin
      n_err++; $display("FAIL hs_ack_drop: got %b required 0", hs_ack);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cpu_a = '0; cpu_d = '0; cpu_ce = 1'b0; cpu_we = 1'b0;
    hs_req = 1'b0; hs_we = 1'b0; hs_a = '0; hs_d = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (wait_n !== 1'b1) begin n_err++; $display("FAIL reset_wait_n: got %b required 1", wait_n); end
    n_cmp++; if (hs_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b required 0", hs_ack); end
    n_cmp++; if (hs_do !== 8'h00) begin n_err++; $display("FAIL reset_hs_do: got %h required 00", hs_do); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read_basic();
    int lat;
    cpu_read(10'h100, lat);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL cpu_read_latency: got %0d required 1", lat); end
    n_cmp++; if (hs_ack !== 1'b0) begin n_err++; $display("FAIL cpu_read_ack: got %b required 0", hs_ack); end
  endtask

  task automatic test_hs_write();
    int wr0, lat;
    wr0 = wr_cnt;
    hs_we = 1'b1; hs_a = 10'h0A0; hs_d = 8'h5A; hs_req = 1'b1;
    shadow[10'h0A0] = 8'h5A;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_HS_ACC || ram_we !== 1'b1) begin n_err++; $display("FAIL hsw_acc: state %0d we %b required %0d 1", dbg_state, ram_we, ST_HS_ACC); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_HS_LAT || ram_we !== 1'b0) begin n_err++; $display("FAIL hsw_lat: state %0d we %b required %0d 0", dbg_state, ram_we, ST_HS_LAT); end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++; if (hs_ack !== 1'b1 || hs_do !== exp_v) begin n_err++; $display("FAIL hsw_ack: ack %b do %h required 1 %h", hs_ack, hs_do, exp_v); end
    repeat (3) @(negedge clk);
    n_cmp++; if (hs_ack !== 1'b1) begin n_err++; $display("FAIL hsw_ack_hold: got %b required 1", hs_ack); end
    hs_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (hs_ack !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL hsw_exit: ack %b state %0d required 0 0", hs_ack, dbg_state); end
    n_cmp++; if (wr_cnt - wr0 != 1) begin n_err++; $display("FAIL hsw_write_count: got %0d required 1", wr_cnt - wr0); end
    cpu_read(10'h0A0, lat);
  endtask

  task automatic test_hs_read_stall();
    int t;
    hs_we = 1'b0; hs_a = 10'h2C3; hs_d = 8'hFF; hs_req = 1'b1;
    exp_q.push_back(shadow[10'h2C3]);
    t = 0;
    do begin @(negedge clk); t++; end while (dbg_state !== ST_HS_LAT && t < 50);
    cpu_a = 10'h101; cpu_we = 1'b0; cpu_ce = 1'b1;
    #1;
    n_cmp++; if (wait_n !== 1'b0) begin n_err++; $display("FAIL stall_lat_wait: got %b required 0", wait_n); end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++; if (dbg_state !== ST_HS_ACK || hs_ack !== 1'b1 || hs_do !== exp_v) begin n_err++; $display("FAIL stall_ack: state %0d ack %b do %h required %0d 1 %h", dbg_state, hs_ack, hs_do, ST_HS_ACK, exp_v); end
    n_cmp++; if (wait_n !== 1'b0) begin n_err++; $display("FAIL stall_ack_wait: got %b required 0", wait_n); end
    hs_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RESTORE || wait_n !== 1'b0 || hs_ack !== 1'b0) begin n_err++; $display("FAIL stall_restore: state %0d wait %b ack %b required %0d 0 0", dbg_state, wait_n, hs_ack, ST_RESTORE); end
    exp_q.push_back(shadow[10'h101]);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++; if (dbg_state !== ST_IDLE || wait_n !== 1'b1 || cpu_do !== exp_v) begin n_err++; $display("FAIL stall_cpu_read: state %0d wait %b do %h required 0 1 %h", dbg_state, wait_n, cpu_do, exp_v); end
    cpu_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starve();
    int n, busy0, lat;
    cpu_a = 10'h155; cpu_d = 8'hC3; cpu_we = 1'b1; cpu_ce = 1'b1;
    shadow[10'h155] = 8'hC3;
    @(negedge clk);
    busy0 = busy_wr_cnt;
    hs_we = 1'b1; hs_a = 10'h1F0; hs_d = 8'h77; hs_req = 1'b1;
    shadow[10'h1F0] = 8'h77;
    exp_q.push_back(8'h77);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dbg_state !== ST_HS_ACC && n < 300);
    n_cmp++; if (n != STARVE + 1) begin n_err++; $display("FAIL starve_cycles: got %0d required %0d", n, STARVE + 1); end
    n_cmp++; if (wait_n !== 1'b0) begin n_err++; $display("FAIL starve_wait: got %b required 0", wait_n); end
    n = 0;
    do begin @(negedge clk); n++; end while (!hs_ack && n < 50);
    exp_v = exp_q.pop_front();
    n_cmp++; if (hs_ack !== 1'b1 || hs_do !== exp_v || wait_n !== 1'b0) begin n_err++; $display("FAIL starve_ack: ack %b do %h wait %b required 1 %h 0", hs_ack, hs_do, wait_n, exp_v); end
    hs_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RESTORE || wait_n !== 1'b0) begin n_err++; $display("FAIL starve_restore: state %0d wait %b required %0d 0", dbg_state, wait_n, ST_RESTORE); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_IDLE || wait_n !== 1'b1) begin n_err++; $display("FAIL starve_idle: state %0d wait %b required 0 1", dbg_state, wait_n); end
    cpu_ce = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy_wr_cnt - busy0 != 1) begin n_err++; $display("FAIL starve_busy_writes: got %0d required 1", busy_wr_cnt - busy0); end
    cpu_read(10'h155, lat);
    cpu_read(10'h1F0, lat);
  endtask

  task automatic test_simultaneous();
    hs_we = 1'b0; hs_a = 10'h333; hs_req = 1'b1;
    cpu_a = 10'h222; cpu_we = 1'b0; cpu_ce = 1'b1;
    exp_q.push_back(shadow[10'h222]);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++; if (dbg_state !== ST_IDLE || wait_n !== 1'b1 || cpu_do !== exp_v) begin n_err++; $display("FAIL simul_cpu: state %0d wait %b do %h required 0 1 %h", dbg_state, wait_n, cpu_do, exp_v); end
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL simul_deferred: state %0d required 0", dbg_state); end
    cpu_ce = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_HS_ACC) begin n_err++; $display("FAIL simul_hs_start: state %0d required %0d", dbg_state, ST_HS_ACC); end
    hs_txn(1'b0, 10'h333, 8'h00);
  endtask

  task automatic test_early_drop();
    int t;
    hs_we = 1'b0; hs_a = 10'h010; hs_req = 1'b1;
    exp_q.push_back(shadow[10'h010]);
    @(negedge clk);
    hs_req = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!hs_ack && t < 20);
    exp_v = exp_q.pop_front();
    n_cmp++; if (hs_ack !== 1'b1 || hs_do !== exp_v) begin n_err++; $display("FAIL early_ack: ack %b do %h required 1 %h", hs_ack, hs_do, exp_v); end
    @(negedge clk);
    n_cmp++; if (hs_ack !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL early_pulse: ack %b state %0d required 0 0", hs_ack, dbg_state); end
  endtask

  task automatic test_reset_mid();
    int t, wr0, lat;
    hs_we = 1'b0; hs_a = 10'h040; hs_req = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (dbg_state !== ST_HS_LAT && t < 50);
    cpu_a = 10'h041; cpu_we = 1'b0; cpu_ce = 1'b1;
    @(negedge clk);
    n_cmp++; if (hs_ack !== 1'b1 || wait_n !== 1'b0) begin n_err++; $display("FAIL mid_pre: ack %b wait %b required 1 0", hs_ack, wait_n); end
    #5 rst_n = 1'b0;
    #1;
    n_cmp++; if (wait_n !== 1'b1 || hs_ack !== 1'b0) begin n_err++; $display("FAIL mid_async: wait %b ack %b required 1 0", wait_n, hs_ack); end
    n_cmp++; if (dbg_state !== ST_IDLE || hs_do !== 8'h00) begin n_err++; $display("FAIL mid_state: state %0d do %h required 0 00", dbg_state, hs_do); end
    wr0 = wr_cnt;
    hs_req = 1'b0; cpu_ce = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (wr_cnt != wr0) begin n_err++; $display("FAIL mid_no_write: got %0d writes required 0", wr_cnt - wr0); end
    hs_txn(1'b1, 10'h050, 8'h9E);
    cpu_read(10'h050, lat);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] <= pat(i);
      shadow[i] = pat(i);
    end
    test_reset();
    test_cpu_read_basic();
    test_hs_write();
    test_hs_read_stall();
    test_starve();
    test_simultaneous();
    test_early_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
